// File: rtl/vc_out_scheduler.sv
// Drain-side scheduler for the per-VC shared buffer: round-robin VC selection,
// commit handshake to the buffer, registered output stage and per-VC credits.
module vc_out_scheduler #(
   parameter int NUM_VC     = 4,
   parameter int DATA_W     = 32,
   parameter int CREDIT_MAX = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_VC-1:0]         vc_nonempty,
   output logic                      commit_ready,
   output logic [$clog2(NUM_VC)-1:0] commit_id,
   input  logic                      buf_valid,
   input  logic [DATA_W-1:0]         buf_data,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data,
   output logic [$clog2(NUM_VC)-1:0] out_vc,
   input  logic                      out_ready,
   input  logic                      credit_ret,
   input  logic [$clog2(NUM_VC)-1:0] credit_ret_vc,
   output logic                      credit_err
);

   localparam int IDW = $clog2(NUM_VC);
   localparam int CW  = $clog2(CREDIT_MAX + 1);
   localparam logic [CW-1:0] CREDIT_FULL = CW'(CREDIT_MAX);

   logic [CW-1:0]     credit [NUM_VC];
   logic [IDW-1:0]    rr_ptr;
   logic [IDW-1:0]    grant;
   logic [IDW-1:0]    commit_id_q;
   logic [NUM_VC-1:0] elig;
   logic              any_elig;
   logic              slot_free;
   logic              pop;

   always_comb begin
      for (int v = 0; v < NUM_VC; v++) begin
         elig[v] = vc_nonempty[v] && (credit[v] != '0);
      end
   end

   assign any_elig  = |elig;
   assign slot_free = !out_valid || out_ready;

   // Scan from rr_ptr upward; NUM_VC is a power of two so the index wraps naturally.
   always_comb begin
      logic [IDW-1:0] idx;
      logic           found;
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_VC; k++) begin
         idx = rr_ptr + IDW'(k);
         if (!found && elig[idx]) begin
            grant = idx;
            found = 1'b1;
         end
      end
   end

   assign commit_ready = slot_free && any_elig;
   assign commit_id    = commit_ready ? grant : commit_id_q;
   assign pop          = commit_ready && buf_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         commit_id_q <= '0;
         rr_ptr      <= '0;
      end else begin
         if (commit_ready) begin
            commit_id_q <= grant;
         end
         if (pop) begin
            rr_ptr <= grant + IDW'(1);
         end
      end
   end

   // A pop reloads the register even while the previous flit drains, sustaining 1 flit/cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_vc    <= '0;
      end else if (pop) begin
         out_valid <= 1'b1;
         out_data  <= buf_data;
         out_vc    <= grant;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Pop and return on the same VC cancel; a return onto a full counter is dropped and flagged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int v = 0; v < NUM_VC; v++) begin
            credit[v] <= CREDIT_FULL;
         end
         credit_err <= 1'b0;
      end else begin
         for (int v = 0; v < NUM_VC; v++) begin
            if (credit_ret && (credit_ret_vc == IDW'(v)) && !(pop && (grant == IDW'(v)))) begin
               if (credit[v] == CREDIT_FULL) begin
                  credit_err <= 1'b1;
               end else begin
                  credit[v] <= credit[v] + CW'(1);
               end
            end else if (pop && (grant == IDW'(v)) && !(credit_ret && (credit_ret_vc == IDW'(v)))) begin
               credit[v] <= credit[v] - CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_vc_out_scheduler.sv
// Bench for vc_out_scheduler: directed scenarios plus random traffic, all
// checked against a cycle-level behavioural model of the scheduling rules.
module tb_vc_out_scheduler;

   localparam int NVC  = 4;
   localparam int CMAX = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  vc_nonempty;
   logic        commit_ready;
   logic [1:0]  commit_id;
   logic        buf_valid;
   logic [31:0] buf_data;
   logic        out_valid;
   logic [31:0] out_data;
   logic [1:0]  out_vc;
   logic        out_ready;
   logic        credit_ret;
   logic [1:0]  credit_ret_vc;
   logic        credit_err;

   int total = 0;
   int bad   = 0;
   int pops_seen;

   // Reference model state
   int          m_credit [NVC];
   int          m_rr;
   int          m_cid;
   bit          m_ov;
   logic [31:0] m_data;
   int          m_vc;
   bit          m_err;
   bit          p_cr;
   int          p_grant;

   vc_out_scheduler #(.NUM_VC(4), .DATA_W(32), .CREDIT_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n), .vc_nonempty(vc_nonempty),
      .commit_ready(commit_ready), .commit_id(commit_id),
      .buf_valid(buf_valid), .buf_data(buf_data),
      .out_valid(out_valid), .out_data(out_data), .out_vc(out_vc),
      .out_ready(out_ready), .credit_ret(credit_ret),
      .credit_ret_vc(credit_ret_vc), .credit_err(credit_err)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      for (int v = 0; v < NVC; v++) m_credit[v] = CMAX;
      m_rr = 0; m_cid = 0; m_ov = 0; m_data = '0; m_vc = 0; m_err = 0;
   endtask

   task automatic applyStimulus(input logic [3:0] ne, input logic bv, input logic [31:0] d,
                                input logic ordy, input logic cret, input logic [1:0] cvc);
      vc_nonempty = ne; buf_valid = bv; buf_data = d;
      out_ready = ordy; credit_ret = cret; credit_ret_vc = cvc;
   endtask

   // Predict this cycle's combinational outputs from the model and compare everything visible.
   task automatic checkOutput();
      bit any;
      any = 0; p_grant = 0;
      for (int k = 0; k < NVC; k++) begin
         int v;
         v = (m_rr + k) % NVC;
         if (!any && vc_nonempty[v] && m_credit[v] > 0) begin
            p_grant = v; any = 1;
         end
      end
      p_cr = (!m_ov || out_ready) && any;
      checkVal("commit_ready", commit_ready, p_cr);
      checkVal("commit_id", commit_id, p_cr ? p_grant : m_cid);
      checkVal("out_valid", out_valid, m_ov);
      if (m_ov) begin
         checkVal("out_data", out_data, m_data);
         checkVal("out_vc", out_vc, m_vc);
      end
      checkVal("credit_err", credit_err, m_err);
      if (commit_ready && buf_valid) pops_seen++;
   endtask

   task automatic advance();
      bit pop;
      @(posedge clk);
      pop = p_cr && buf_valid;
      for (int v = 0; v < NVC; v++) begin
         bit dec, inc;
         dec = pop && (p_grant == v);
         inc = credit_ret && (credit_ret_vc == v);
         if (inc && !dec) begin
            if (m_credit[v] == CMAX) m_err = 1;
            else m_credit[v]++;
         end else if (dec && !inc) begin
            m_credit[v]--;
         end
      end
      if (p_cr) m_cid = p_grant;
      if (pop) begin
         m_ov = 1; m_data = buf_data; m_vc = p_grant; m_rr = (p_grant + 1) % NVC;
      end else if (m_ov && out_ready) begin
         m_ov = 0;
      end
      #1;
   endtask

   task automatic runCycle(input logic [3:0] ne, input logic bv, input logic [31:0] d,
                           input logic ordy, input logic cret, input logic [1:0] cvc);
      applyStimulus(ne, bv, d, ordy, cret, cvc);
      #3;
      checkOutput();
      advance();
   endtask

   task automatic doReset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      applyStimulus(4'b0000, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
      modelReset();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(4'b0000, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
      modelReset();
      pops_seen = 0;
      #3;
      checkVal("reset_commit_ready", commit_ready, 1'b0);
      checkVal("reset_out_valid", out_valid, 1'b0);
      checkVal("reset_out_data", out_data, 32'h0);
      checkVal("reset_credit_err", credit_err, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      $display("[TB] single flit");
      applyStimulus(4'b0100, 1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 2'd0);
      #3;
      checkOutput();
      checkVal("single_commit_ready", commit_ready, 1'b1);
      checkVal("single_commit_id", commit_id, 2);
      advance();
      applyStimulus(4'b0000, 1'b0, 32'h0, 1'b1, 1'b0, 2'd0);
      #3;
      checkOutput();
      checkVal("single_out_valid", out_valid, 1'b1);
      checkVal("single_out_data", out_data, 32'hA5A5_0001);
      checkVal("single_out_vc", out_vc, 2);
      advance();

      $display("[TB] round robin");
      doReset();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(4'b1111, 1'b1, 32'hC000_0000 + i, 1'b1, 1'b0, 2'd0);
         #3;
         checkOutput();
         checkVal("rr_commit_id", commit_id, i % 4);
         advance();
      end

      $display("[TB] credit exhaustion");
      doReset();
      pops_seen = 0;
      for (int i = 0; i < 6; i++) runCycle(4'b0010, 1'b1, 32'hD000_0000 + i, 1'b1, 1'b0, 2'd0);
      checkVal("exhaust_pops", pops_seen, 4);
      runCycle(4'b0010, 1'b1, 32'hD000_0010, 1'b1, 1'b1, 2'd1);
      pops_seen = 0;
      runCycle(4'b0010, 1'b1, 32'hD000_0011, 1'b1, 1'b0, 2'd0);
      runCycle(4'b0010, 1'b1, 32'hD000_0012, 1'b1, 1'b0, 2'd0);
      checkVal("exhaust_refill_pops", pops_seen, 1);

      $display("[TB] backpressure");
      doReset();
      runCycle(4'b1111, 1'b1, 32'hB0B0_0000, 1'b1, 1'b0, 2'd0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(4'b1111, 1'b1, 32'hBAD0_0000 + i, 1'b0, 1'b0, 2'd0);
         #3;
         checkOutput();
         checkVal("hold_commit_ready", commit_ready, 1'b0);
         checkVal("hold_out_data", out_data, 32'hB0B0_0000);
         advance();
      end
      applyStimulus(4'b1111, 1'b1, 32'hB0B0_0001, 1'b1, 1'b0, 2'd0);
      #3;
      checkOutput();
      checkVal("release_commit_ready", commit_ready, 1'b1);
      advance();
      runCycle(4'b0000, 1'b0, 32'h0, 1'b1, 1'b0, 2'd0);

      $display("[TB] simultaneous pop and return on VC3");
      doReset();
      runCycle(4'b1000, 1'b1, 32'h3333_0001, 1'b1, 1'b0, 2'd0);
      runCycle(4'b1000, 1'b1, 32'h3333_0002, 1'b1, 1'b0, 2'd0);
      runCycle(4'b1000, 1'b1, 32'h3333_0003, 1'b1, 1'b1, 2'd3);
      pops_seen = 0;
      for (int i = 0; i < 4; i++) runCycle(4'b1000, 1'b1, 32'h3333_0010 + i, 1'b1, 1'b0, 2'd0);
      checkVal("vc3_net_zero_pops", pops_seen, 2);

      $display("[TB] random traffic");
      doReset();
      for (int i = 0; i < 300; i++) begin
         logic [1:0] cvc;
         logic       cret;
         cvc  = 2'($urandom_range(0, 3));
         cret = ($urandom_range(0, 1) == 1) && (m_credit[cvc] < CMAX);
         runCycle(4'($urandom), $urandom_range(0, 3) != 0, $urandom,
                  $urandom_range(0, 3) != 0, cret, cvc);
      end

      $display("[TB] credit overflow");
      doReset();
      runCycle(4'b0000, 1'b0, 32'h0, 1'b1, 1'b1, 2'd0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'b0001, 1'b1, 32'hE000_0000 + i, 1'b1, 1'b0, 2'd0);
         #3;
         checkOutput();
         checkVal("overflow_err_sticky", credit_err, 1'b1);
         advance();
      end

      $display("[TB] async reset mid-operation");
      doReset();
      for (int i = 0; i < 3; i++) runCycle(4'b0001, 1'b1, 32'hF000_0000 + i, 1'b1, 1'b0, 2'd0);
      #1 rst_n = 1'b0;
      #1;
      checkVal("async_out_valid", out_valid, 1'b0);
      checkVal("async_credit_err", credit_err, 1'b0);
      modelReset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      applyStimulus(4'b1111, 1'b1, 32'hF100_0000, 1'b1, 1'b0, 2'd0);
      #3;
      checkOutput();
      checkVal("post_reset_commit_id", commit_id, 0);
      advance();
      pops_seen = 0;
      for (int i = 0; i < 6; i++) runCycle(4'b0001, 1'b1, 32'hF200_0000 + i, 1'b1, 1'b0, 2'd0);
      checkVal("post_reset_vc0_pops", pops_seen, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
